serial_capture: RTL
===================

# serial_capture

Synthesizable, parametrised UART receive monitor that captures characters from a serial line into an on-chip buffer and reports completion by character count or by terminator byte. It sits beside the CPU's on-chip UART transmitter (tapping `serial_out`) and lets simulation benches or on-board debug logic collect program output without a host-side model. It generalises the fixed 10-bit, fixed-count capture used in our software-test benches. It adds configurable baud, data width, buffer depth, a stop condition, framing-error detection and a readback port.

## Interface
- `CLOCK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD_RATE`, 10_000_000, line rate. `CPB = CLOCK_FREQ/BAUD_RATE`, minimum 4.
- `DATA_BITS`, 8, data bits per frame, from 5 to 8, LSB first.
- `DEPTH`, 256, buffer entries. Must be a power of two.
- `TERMINATOR`, 8'h0A, byte that ends capture when `term_en`=1.
- Derived: `AW = $clog2(DEPTH)`, `CW = $clog2(DEPTH+1)`.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: asynchronous, active-high reset.
- `serial_in` input 1: monitored line; idles high.
- `clear` input 1: synchronous one-cycle pulse that restarts capture.
- `target_count` input CW: stop after this many characters. 0 means no count limit.
- `term_en` input 1: enables the terminator stop condition.
- `char_valid` output 1: one-cycle pulse when a character is accepted.
- `char_data` output 8: last accepted character, zero-extended above `DATA_BITS`.
- `count` output CW: number of characters stored.
- `done` output 1: sticky; capture has finished.
- `overflow` output 1: sticky; a character arrived while the buffer was full.
- `frame_err_count` output 8: saturating count of bad stop bits.
- `rd_addr` input AW: buffer read address.
- `rd_data` output 8: buffer word at `rd_addr`.

## Operation
- `serial_in` passes through a 2-flop synchronizer, reset value 1. All decisions below use the synchronized value `s`.
- FSM states:
  - IDLE: go to START when `s`=0.
  - START: wait `CPB/2` cycles, then sample. If `s`=1 it was a glitch, return to IDLE. If `s`=0 go to DATA.
  - DATA: sample every `CPB` cycles. Shift bits in LSB first until `DATA_BITS` bits are collected, then go to STOP.
  - STOP: wait `CPB` cycles, sample, return to IDLE.
- Stop sample = 1: the character is accepted, unless `done` is 1 (in that case it is silently ignored).
  - Accept with `count` < DEPTH: write to `mem[count]`, `count`++, pulse `char_valid`, update `char_data`.
  - Accept with `count` == DEPTH: set `overflow`. Nothing is written, `count` holds, no pulse.
- Stop sample = 0: framing error. `frame_err_count`++ (saturates at 255). The character is discarded. No pulse.
- `done` sets in the same cycle as an accepted write when either condition holds:
  - `target_count`≠0 and the new `count` == `target_count`;
  - `term_en`=1 and the character == `TERMINATOR`.
- `done` also sets when `overflow` sets.
- `clear`: zeroes `count`, `done`, `overflow`, `frame_err_count` and `char_valid`, and forces the FSM to IDLE. Buffer contents are kept.
- If `clear` and a stop-bit acceptance occur in the same cycle, `clear` wins and the character is dropped.
- `target_count` < current `count` never triggers `done`; only equality on increment does.
- Read port: synchronous read-first. A read of an address being written in the same cycle returns the old data.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in IDLE; synchronizer flops 1.
  - `rd_data` is 0 until the first read clock edge after reset.
- Reset mid-frame aborts the frame. No partial character is written.
- Detection latency: 2 cycles of synchronizer delay after the line edge.
- `char_valid`, `count`, `done` and `char_data` all update on the same edge: the stop-bit sample edge. This is about 2 + `CPB/2` + (`DATA_BITS`+1)·`CPB` cycles after the start edge.
- `rd_data` is valid 1 cycle after `rd_addr` is presented.
- Back-to-back frames are supported. The FSM returns to IDLE mid-stop-bit, so it is ready for the next start edge.

## Test plan
- Reset, then `CPB`=5 and `target_count`=0. Send 0x41 with a good stop bit.
  - Expect one `char_valid` pulse and `char_data`=0x41.
  - Expect `count`=1 and `done`=0.
  - Expect `rd_addr`=0 to give `rd_data`=0x41 the next cycle.
- Count stop: `target_count`=3, send "abcd".
  - Expect `done`=1 on the stop sample of 'c' and `count`=3.
  - 'd' produces no pulse; `mem[3]` is unchanged.
- Terminator stop: `term_en`=1, `target_count`=0, send "hi\n".
  - Expect `done`=1 and `count`=3.
  - Expect `mem[2]`=0x0A.
- Framing error and glitch:
  - A frame with stop bit 0 gives `frame_err_count`=1, `count` unchanged, no pulse.
  - A 1-cycle low glitch gives no capture and the FSM back in IDLE.
- Overflow: `DEPTH`=4, send 5 characters.
  - Expect `count`=4, `overflow`=1, `done`=1.
  - `mem[0..3]` hold the first four characters.
- Clear and reset:
  - `clear` coincident with a stop sample drops the character and leaves `count`=0.
  - `rst` asserted mid-DATA gives all outputs 0 and no write.
  - The next full frame is captured correctly.

Source files
------------

// File: rtl/serial_capture_if.sv
// serial_capture_if: groups the serial_capture line, control, status and readback signals.
//   master (bench/debug side) drives: serial_in, clear, target_count, term_en, rd_addr
//   slave  (serial_capture) drives:   char_valid, char_data, count, done, overflow,
//                                     frame_err_count, rd_data
//   DEPTH must match the serial_capture instance; AW/CW follow from it.
interface serial_capture_if #(parameter int DEPTH = 256);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic          serial_in;
   logic          clear;
   logic [CW-1:0] target_count;
   logic          term_en;
   logic          char_valid;
   logic [7:0]    char_data;
   logic [CW-1:0] count;
   logic          done;
   logic          overflow;
   logic [7:0]    frame_err_count;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   modport master (
      output serial_in, clear, target_count, term_en, rd_addr,
      input  char_valid, char_data, count, done, overflow, frame_err_count, rd_data
   );
   modport slave (
      input  serial_in, clear, target_count, term_en, rd_addr,
      output char_valid, char_data, count, done, overflow, frame_err_count, rd_data
   );
endinterface

// File: rtl/serial_capture.sv
// serial_capture: UART receive monitor that stores accepted characters in a buffer and
// flags completion by character count, terminator byte or buffer overflow.
//   clk, rst          : single clock, asynchronous active-high reset
//   bus.serial_in     : monitored line (idles high), synchronized internally
//   bus.clear         : one-cycle pulse restarting capture (buffer contents kept)
//   bus.target_count  : stop after this many characters, 0 = unlimited
//   bus.term_en       : stop on TERMINATOR
//   bus.char_valid    : one-cycle pulse per accepted character
//   bus.char_data     : last accepted character, zero-extended
//   bus.count         : characters stored
//   bus.done          : sticky capture-finished flag
//   bus.overflow      : sticky, a character arrived while the buffer was full
//   bus.frame_err_count : saturating count of bad stop bits
//   bus.rd_addr/rd_data : synchronous read-first buffer readback
module serial_capture #(
   parameter int         CLOCK_FREQ = 50_000_000,
   parameter int         BAUD_RATE  = 10_000_000,
   parameter int         DATA_BITS  = 8,
   parameter int         DEPTH      = 256,
   parameter logic [7:0] TERMINATOR = 8'h0A
) (
   input logic               clk,
   input logic               rst,
   serial_capture_if.slave   bus
);
   localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF = CPB / 2;
   localparam int TW   = $clog2(CPB);
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t               state;
   logic                 s1, s;
   logic [TW-1:0]        tick;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic [7:0]           mem [DEPTH];
   logic                 stop_edge, we, hit;
   assign stop_edge = state == STOP && tick == TW'(CPB - 1);
   // clear and an already-finished capture both suppress the write
   assign we  = stop_edge && s && !bus.clear && !bus.done && bus.count < CW'(DEPTH);
   assign hit = (bus.target_count != '0 && bus.count + CW'(1) == bus.target_count) ||
                (bus.term_en && 8'(shift) == TERMINATOR);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= 1'b1;
         s  <= 1'b1;
      end else begin
         s1 <= bus.serial_in;
         s  <= s1;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state               <= IDLE;
         tick                <= '0;
         bit_idx             <= '0;
         shift               <= '0;
         bus.char_valid      <= 1'b0;
         bus.char_data       <= '0;
         bus.count           <= '0;
         bus.done            <= 1'b0;
         bus.overflow        <= 1'b0;
         bus.frame_err_count <= '0;
      end else if (bus.clear) begin
         state               <= IDLE;
         tick                <= '0;
         bus.char_valid      <= 1'b0;
         bus.count           <= '0;
         bus.done            <= 1'b0;
         bus.overflow        <= 1'b0;
         bus.frame_err_count <= '0;
      end else begin
         bus.char_valid <= we;
         case (state)
            IDLE: begin
               tick    <= '0;
               bit_idx <= '0;
               if (!s) state <= START;
            end
            START:
               if (tick == TW'(HALF - 1)) begin
                  tick  <= '0;
                  state <= s ? IDLE : DATA;
               end else tick <= tick + TW'(1);
            DATA:
               if (tick == TW'(CPB - 1)) begin
                  tick           <= '0;
                  shift[bit_idx] <= s;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
               end else tick <= tick + TW'(1);
            STOP:
               if (stop_edge) begin
                  // returning mid-stop-bit leaves time to catch a back-to-back start edge
                  state <= IDLE;
                  tick  <= '0;
                  if (!s) begin
                     if (bus.frame_err_count != 8'hFF) bus.frame_err_count <= bus.frame_err_count + 8'd1;
                  end else if (we) begin
                     bus.count     <= bus.count + CW'(1);
                     bus.char_data <= 8'(shift);
                     bus.done      <= hit;
                  end else if (!bus.done) begin
                     bus.overflow <= 1'b1;
                     bus.done     <= 1'b1;
                  end
               end else tick <= tick + TW'(1);
            default: state <= IDLE;
         endcase
      end
   always_ff @(posedge clk)
      if (we) mem[bus.count[AW-1:0]] <= 8'(shift);
   always_ff @(posedge clk or posedge rst)
      if (rst) bus.rd_data <= '0;
      else     bus.rd_data <= mem[bus.rd_addr];
endmodule
